// File: rtl/data_reg_stream.sv
// Double-buffered register bank: loader writes a live set, a start pulse
// snapshots it into a shadow set which is streamed out over valid/ready.
module data_reg_stream #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] rom_output,
  input  logic [ADDR_W-1:0] address,
  input  logic              writeData,
  input  logic              start_network,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic [DEPTH-1:0]  valid_mask,
  output logic              start_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t state, state_nx;

  logic [DATA_W-1:0] live   [DEPTH];
  logic [DATA_W-1:0] shadow [DEPTH];
  logic [ADDR_W-1:0] idx;

  logic go;
  logic hs;
  logic at_last;

  assign at_last = (idx == ADDR_W'(DEPTH - 1));
  assign go      = start_network && (state == IDLE) && (&valid_mask);
  assign hs      = (state == STREAM) && out_ready;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (go) state_nx = STREAM;
      STREAM:  if (hs && at_last) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    out_valid = (state == STREAM);
    out_last  = out_valid && at_last;
    out_data  = out_valid ? shadow[idx] : '0;
    busy      = (state != IDLE);
    done      = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        live[i]   <= '0;
        shadow[i] <= '0;
      end
    end else begin
      if (go) begin
        for (int i = 0; i < DEPTH; i++) shadow[i] <= live[i];
      end
      if (writeData) live[address] <= rom_output;
    end
  end

  // Same-cycle write wins over the snapshot clear of its valid bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_mask <= '0;
    end else begin
      if (go) valid_mask <= '0;
      if (writeData) valid_mask[address] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx <= '0;
    end else if (go) begin
      idx <= '0;
    end else if (hs) begin
      idx <= at_last ? '0 : idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) start_err <= 1'b0;
    else       start_err <= start_network && !go;
  end

endmodule

// File: tb/tb_data_reg_stream.sv
// Randomized bench for data_reg_stream against a queue-based model
// of the live/shadow banks and the streamed word sequence.
module tb_data_reg_stream;

  logic        clk;
  logic        reset;
  logic [31:0] rom_output;
  logic [1:0]  address;
  logic        writeData;
  logic        start_network;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        busy;
  logic        done;
  logic [3:0]  valid_mask;
  logic        start_err;

  int vec;
  int miss;

  logic [31:0] m_live [4];
  logic [3:0]  m_mask;
  logic [31:0] q[$];
  logic        m_done;
  logic        m_err;

  data_reg_stream dut (
    .clk(clk),
    .reset(reset),
    .rom_output(rom_output),
    .address(address),
    .writeData(writeData),
    .start_network(start_network),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_last(out_last),
    .busy(busy),
    .done(done),
    .valid_mask(valid_mask),
    .start_err(start_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [8:0] exp_flags();
    return {q.size() > 0, q.size() == 1,
            q.size() > 0 || m_done, m_done, m_err, m_mask};
  endfunction

  function automatic logic [31:0] exp_data();
    return (q.size() > 0) ? q[0] : 32'h0;
  endfunction

  function automatic logic [8:0] flags();
    return {out_valid, out_last, busy, done, start_err, valid_mask};
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 4; i++) m_live[i] = '0;
    m_mask = '0;
    q.delete();
    m_done = 1'b0;
    m_err  = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    writeData = 1'b0;
    start_network = 1'b0;
    model_clear();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // One clock: drive inputs, advance the model by the spec rules, sample.
  task automatic step(input logic wr, input logic [1:0] a,
                      input logic [31:0] d, input logic st,
                      input logic rdy);
    logic busy_pre;
    logic done_nx;
    writeData = wr;
    address = a;
    rom_output = d;
    start_network = st;
    out_ready = rdy;
    busy_pre = (q.size() > 0) || m_done;
    done_nx = 1'b0;
    if (q.size() > 0 && rdy) begin
      void'(q.pop_front());
      if (q.size() == 0) done_nx = 1'b1;
    end
    m_err = 1'b0;
    if (st) begin
      if (!busy_pre && m_mask == 4'hF) begin
        for (int i = 0; i < 4; i++) q.push_back(m_live[i]);
        m_mask = '0;
      end else begin
        m_err = 1'b1;
      end
    end
    if (wr) begin
      m_live[a] = d;
      m_mask[a] = 1'b1;
    end
    m_done = done_nx;
    @(posedge clk);
    #1;
    writeData = 1'b0;
    start_network = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    vec++;
    if (flags() !== 9'h0) begin
      miss++;
      $display("FAIL reset flags: got %b want %b", flags(), 9'h0);
    end
    vec++;
    if (out_data !== 32'h0) begin
      miss++;
      $display("FAIL reset data: got %h want 0", out_data);
    end
  endtask

  task automatic test_basic();
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 2'(i), $urandom, 1'b0, 1'b1);
    step(1'b0, 2'd0, 32'h0, 1'b1, 1'b1);
    for (int k = 0; k < 8; k++) begin
      vec++;
      if (flags() !== exp_flags()) begin
        miss++;
        $display("FAIL basic flags k=%0d: got %b want %b", k, flags(), exp_flags());
      end
      vec++;
      if (out_data !== exp_data()) begin
        miss++;
        $display("FAIL basic data k=%0d: got %h want %h", k, out_data, exp_data());
      end
      step(1'b0, 2'd0, 32'h0, 1'b0, 1'b1);
    end
  endtask

  task automatic test_incomplete();
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 2'(i), $urandom, 1'b0, 1'b1);
    step(1'b0, 2'd0, 32'h0, 1'b1, 1'b1);
    vec++;
    if (flags() !== {5'b00001, 4'b0111}) begin
      miss++;
      $display("FAIL incomplete err: got %b want %b", flags(), {5'b00001, 4'b0111});
    end
    step(1'b0, 2'd0, 32'h0, 1'b0, 1'b1);
    vec++;
    if (flags() !== exp_flags()) begin
      miss++;
      $display("FAIL incomplete after: got %b want %b", flags(), exp_flags());
    end
  endtask

  task automatic test_backpressure();
    logic pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    int hs_cnt;
    do_reset();
    hs_cnt = 0;
    for (int i = 0; i < 4; i++) step(1'b1, 2'(i), $urandom, 1'b0, 1'b0);
    step(1'b0, 2'd0, 32'h0, 1'b1, 1'b0);
    for (int k = 0; k < 40 && (q.size() > 0 || m_done); k++) begin
      logic r;
      r = (k < 6) ? pat[k] : 1'($urandom_range(0, 1));
      if (out_valid && r) hs_cnt++;
      step(1'b0, 2'd0, 32'h0, 1'b0, r);
      vec++;
      if (flags() !== exp_flags()) begin
        miss++;
        $display("FAIL bp flags k=%0d: got %b want %b", k, flags(), exp_flags());
      end
      vec++;
      if (out_data !== exp_data()) begin
        miss++;
        $display("FAIL bp data k=%0d: got %h want %h", k, out_data, exp_data());
      end
    end
    vec++;
    if (hs_cnt !== 4 || q.size() != 0) begin
      miss++;
      $display("FAIL bp handshakes: got %0d want 4", hs_cnt);
    end
  endtask

  task automatic test_preload();
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 2'(i), $urandom, 1'b0, 1'b1);
    step(1'b0, 2'd0, 32'h0, 1'b1, 1'b1);
    for (int round = 0; round < 2; round++) begin
      for (int k = 0; k < 6; k++) begin
        vec++;
        if (flags() !== exp_flags()) begin
          miss++;
          $display("FAIL preload flags r=%0d k=%0d: got %b want %b",
                   round, k, flags(), exp_flags());
        end
        vec++;
        if (out_data !== exp_data()) begin
          miss++;
          $display("FAIL preload data r=%0d k=%0d: got %h want %h",
                   round, k, out_data, exp_data());
        end
        if (round == 0 && k < 4) step(1'b1, 2'(k), $urandom, 1'b0, 1'b1);
        else                     step(1'b0, 2'd0, 32'h0, 1'b0, 1'b1);
      end
      step(1'b0, 2'd0, 32'h0, 1'b1, 1'b1);
    end
  endtask

  task automatic test_start_busy();
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 2'(i), $urandom, 1'b0, 1'b0);
    step(1'b0, 2'd0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 2'd0, 32'h0, 1'b1, 1'b1);
    vec++;
    if (flags() !== exp_flags()) begin
      miss++;
      $display("FAIL busy start err: got %b want %b", flags(), exp_flags());
    end
    for (int k = 0; k < 6; k++) begin
      step(1'b0, 2'd0, 32'h0, (k == 3), 1'b1);
      vec++;
      if (flags() !== exp_flags() || out_data !== exp_data()) begin
        miss++;
        $display("FAIL busy stream k=%0d: got %b/%h want %b/%h",
                 k, flags(), out_data, exp_flags(), exp_data());
      end
    end
    for (int i = 0; i < 4; i++) step(1'b1, 2'(i), $urandom, 1'b0, 1'b1);
    step(1'b1, 2'd3, $urandom, 1'b1, 1'b0);
    vec++;
    if (valid_mask !== 4'b1000) begin
      miss++;
      $display("FAIL same-cycle mask: got %b want 1000", valid_mask);
    end
    for (int k = 0; k < 6; k++) begin
      vec++;
      if (flags() !== exp_flags() || out_data !== exp_data()) begin
        miss++;
        $display("FAIL same-cycle stream k=%0d: got %b/%h want %b/%h",
                 k, flags(), out_data, exp_flags(), exp_data());
      end
      step(1'b0, 2'd0, 32'h0, 1'b0, 1'b1);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 2'(i), $urandom, 1'b0, 1'b1);
    step(1'b0, 2'd0, 32'h0, 1'b1, 1'b1);
    step(1'b0, 2'd0, 32'h0, 1'b0, 1'b1);
    vec++;
    if (out_data !== exp_data() || !out_valid) begin
      miss++;
      $display("FAIL mid word2: got %h want %h", out_data, exp_data());
    end
    out_ready = 1'b1;
    do_reset();
    vec++;
    if (flags() !== 9'h0) begin
      miss++;
      $display("FAIL mid reset: got %b want %b", flags(), 9'h0);
    end
    step(1'b0, 2'd0, 32'h0, 1'b0, 1'b1);
    vec++;
    if (flags() !== 9'h0 || out_data !== 32'h0) begin
      miss++;
      $display("FAIL mid no-done: got %b/%h want 0/0", flags(), out_data);
    end
  endtask

  initial begin
    vec = 0;
    miss = 0;
    reset = 1'b1;
    rom_output = '0;
    address = '0;
    writeData = 1'b0;
    start_network = 1'b0;
    out_ready = 1'b0;
    model_clear();
    test_reset();
    test_basic();
    test_incomplete();
    test_backpressure();
    test_preload();
    test_start_busy();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
